// File: rtl/io_trace_monitor.sv
// I/O write tracer and run supervisor for the 8-bit microcontroller: captures masked port
// writes into a timestamped FIFO and flags program halt (repeated PC fetch) or run timeout.
module io_trace_monitor #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int PC_W     = 8,
    parameter int DEPTH    = 16,
    parameter int TS_W     = 16,
    parameter int HALT_REP = 3,
    parameter int TIMEOUT  = 1000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [2**ADDR_W-1:0]     port_mask,
    input  logic [ADDR_W-1:0]        io_addr,
    input  logic [DATA_W-1:0]        io_data,
    input  logic                     io_we,
    input  logic                     ifetch,
    input  logic [PC_W-1:0]          pc,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [TS_W-1:0]          rd_ts,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [1:0]               state,
    output logic [TS_W-1:0]          cycles
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REP_W = $clog2(HALT_REP + 1);
    localparam int ENT_W = TS_W + ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [TS_W-1:0]    cycles_q, cycles_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               rd_valid_q, rd_valid_d;
    logic [TS_W-1:0]    rd_ts_q, rd_ts_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic [PC_W-1:0]    last_pc_q, last_pc_d;
    logic [REP_W-1:0]   rep_q, rep_d;

    logic [ENT_W-1:0]   fifo_mem [DEPTH];
    logic [ENT_W-1:0]   head_entry;
    logic               push, pop, full, wr_en, halt_hit, timeout_hit;

    assign head_entry = fifo_mem[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        cycles_d    = cycles_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        rd_valid_d  = 1'b0;
        rd_ts_d     = rd_ts_q;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        last_pc_d   = last_pc_q;
        rep_d       = rep_q;
        halt_hit    = 1'b0;
        timeout_hit = 1'b0;

        push  = (state_q == ST_RUN) && io_we && port_mask[io_addr];
        pop   = rd_en && (count_q != '0);
        full  = (count_q == CNT_W'(DEPTH));
        // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
        wr_en = push && (!full || pop);

        if (push && full && !pop) begin
            overflow_d = 1'b1;
        end
        if (pop) begin
            rd_valid_d = 1'b1;
            rd_ts_d    = head_entry[ENT_W-1 -: TS_W];
            rd_addr_d  = head_entry[DATA_W +: ADDR_W];
            rd_data_d  = head_entry[DATA_W-1:0];
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // rep_q == 0 means no fetch seen yet, so the first fetch never matches a stale PC.
        case (state_q)
            ST_RUN: begin
                if (ifetch) begin
                    last_pc_d = pc;
                    if ((rep_q != '0) && (pc == last_pc_q)) begin
                        rep_d = rep_q + REP_W'(1);
                    end else begin
                        rep_d = REP_W'(1);
                    end
                    halt_hit = (rep_d == REP_W'(HALT_REP));
                end
                timeout_hit = (cycles_q == TS_W'(TIMEOUT - 1));
                if (halt_hit) begin
                    state_d = ST_HALTED;
                end else if (timeout_hit) begin
                    state_d = ST_TIMEOUT;
                end else begin
                    cycles_d = cycles_q + TS_W'(1);
                end
            end
            default: begin
                if (start) begin
                    state_d    = ST_RUN;
                    cycles_d   = '0;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    last_pc_d  = '0;
                    rep_d      = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cycles_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_ts_q    <= '0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            last_pc_q  <= '0;
            rep_q      <= '0;
        end else begin
            state_q    <= state_d;
            cycles_q   <= cycles_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rd_valid_q <= rd_valid_d;
            rd_ts_q    <= rd_ts_d;
            rd_addr_q  <= rd_addr_d;
            rd_data_q  <= rd_data_d;
            last_pc_q  <= last_pc_d;
            rep_q      <= rep_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem[wr_ptr_q] <= {cycles_q, io_addr, io_data};
        end
    end

    assign state    = state_q;
    assign cycles   = cycles_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign rd_valid = rd_valid_q;
    assign rd_ts    = rd_ts_q;
    assign rd_addr  = rd_addr_q;
    assign rd_data  = rd_data_q;

endmodule
